// File: rtl/bpu_ps_arbiter.sv
// Predictor-state RAM port arbiter: init sweep, update queue, read/write sharing.
// Optional read-after-write forwarding from the update queue: define BPU_PS_FWD_EN.
//
// state | meaning
// INIT  | writing weak-NT to every PS entry, one per cycle; RAM reads blocked
// RUN   | fetch reads and queued counter updates share the single RAM port
module bpu_ps_arbiter #(
  parameter int PS_SIZE = 8,
  parameter int UQ_LOG2 = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bpu_flush,
  input  logic               fch_predict,
  input  logic [PS_SIZE-1:0] fch_addr_nxt,
  input  logic               wrb_update_bpu,
  input  logic               wrb_was_pred,
  input  logic [1:0]         wrb_ps_state,
  input  logic [PS_SIZE-1:0] wrb_ps_addr,
  input  logic               wrb_direction,
  input  logic [1:0]         ps_rd_data,
  output logic               ps_rd_en,
  output logic               ps_wr_en,
  output logic [PS_SIZE-1:0] ps_addr,
  output logic [1:0]         ps_wr_data,
  output logic [1:0]         fch_pred_state,
  output logic               fch_pred_valid,
  output logic               bpu_busy,
  output logic               uq_full
);

  localparam int UQ_DEPTH = 1 << UQ_LOG2;
  localparam logic [PS_SIZE-1:0] SWEEP_LAST = '1;
  localparam logic [1:0] WEAK_NT = 2'b01;

  typedef enum logic {INIT, RUN} state_t;

  state_t               state;
  logic [PS_SIZE-1:0]   sweep_cnt;
  logic [PS_SIZE+1:0]   uq_mem [UQ_DEPTH];
  logic [UQ_LOG2:0]     wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [UQ_LOG2-1:0]   wr_idx, rd_idx;
  logic [PS_SIZE+1:0]   uq_head;
  logic                 uq_full_r, uq_empty;
  logic                 rd_granted_r;
  logic                 active, run, rd_grant, pop, push;
  logic [1:0]           base, upd_state;

  assign wr_idx   = wr_ptr[UQ_LOG2-1:0];
  assign rd_idx   = rd_ptr[UQ_LOG2-1:0];
  assign uq_head  = uq_mem[rd_idx];
  assign uq_empty = (wr_ptr == rd_ptr);

  // Flush and reset both silence the port in the cycle they are asserted.
  assign active   = !reset && !bpu_flush;
  assign run      = active && (state == RUN);
  assign rd_grant = run && !uq_full_r && fch_predict;
  assign pop      = run && (uq_full_r || (!fch_predict && !uq_empty));
  assign push     = run && wrb_update_bpu;

  assign wr_nxt = wr_ptr + {{UQ_LOG2{1'b0}}, push};
  assign rd_nxt = rd_ptr + {{UQ_LOG2{1'b0}}, pop};

  always_comb begin
    base = wrb_was_pred ? wrb_ps_state : WEAK_NT;
    if (wrb_direction) upd_state = (base == 2'b11) ? base : base + 2'd1;
    else               upd_state = (base == 2'b00) ? base : base - 2'd1;
  end

  always_comb begin
    ps_rd_en   = 1'b0;
    ps_wr_en   = 1'b0;
    ps_addr    = '0;
    ps_wr_data = WEAK_NT;
    if (active && state == INIT) begin
      ps_wr_en = 1'b1;
      ps_addr  = sweep_cnt;
    end else if (pop) begin
      ps_wr_en   = 1'b1;
      ps_addr    = uq_head[PS_SIZE+1:2];
      ps_wr_data = uq_head[1:0];
    end else if (rd_grant) begin
      ps_rd_en = 1'b1;
      ps_addr  = fch_addr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bpu_flush) begin
      state        <= INIT;
      sweep_cnt    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      uq_full_r    <= 1'b0;
      rd_granted_r <= 1'b0;
      for (int i = 0; i < UQ_DEPTH; i++) uq_mem[i] <= '0;
    end else begin
      rd_granted_r <= rd_grant;
      if (state == INIT) begin
        sweep_cnt <= sweep_cnt + PS_SIZE'(1);
        if (sweep_cnt == SWEEP_LAST) state <= RUN;
      end
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      uq_full_r <= ((wr_nxt ^ rd_nxt) == {1'b1, {UQ_LOG2{1'b0}}});
      if (push) uq_mem[wr_idx] <= {wrb_ps_addr, upd_state};
    end
  end

  assign uq_full        = uq_full_r;
  assign bpu_busy       = (state == INIT);
  assign fch_pred_valid = rd_granted_r;

`ifdef BPU_PS_FWD_EN
  logic [UQ_LOG2:0]   uq_count;
  logic [UQ_LOG2-1:0] slot;
  logic               fwd_hit, fwd_hit_r;
  logic [1:0]         fwd_state, fwd_state_r;

  assign uq_count = wr_ptr - rd_ptr;

  // Later matches overwrite earlier ones, so the youngest queued state wins;
  // the entry being pushed this cycle is younger than anything in the queue.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_state = WEAK_NT;
    slot      = rd_idx;
    for (int i = 0; i < UQ_DEPTH; i++) begin
      slot = rd_idx + i[UQ_LOG2-1:0];
      if (i < int'(uq_count) && uq_mem[slot][PS_SIZE+1:2] == fch_addr_nxt) begin
        fwd_hit   = 1'b1;
        fwd_state = uq_mem[slot][1:0];
      end
    end
    if (push && wrb_ps_addr == fch_addr_nxt) begin
      fwd_hit   = 1'b1;
      fwd_state = upd_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bpu_flush) begin
      fwd_hit_r   <= 1'b0;
      fwd_state_r <= WEAK_NT;
    end else begin
      fwd_hit_r   <= rd_grant && fwd_hit;
      fwd_state_r <= fwd_state;
    end
  end

  assign fch_pred_state = !rd_granted_r ? WEAK_NT : (fwd_hit_r ? fwd_state_r : ps_rd_data);
`else
  assign fch_pred_state = rd_granted_r ? ps_rd_data : WEAK_NT;
`endif

endmodule

// File: tb/tb_bpu_ps_arbiter.sv
// Directed bench for bpu_ps_arbiter (PS_SIZE=4, UQ_LOG2=2) with a behavioural PS RAM.
module tb_bpu_ps_arbiter;

  localparam int PS_SIZE = 4;
  localparam int UQ_LOG2 = 2;
`ifdef BPU_PS_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bpu_flush = 1'b0;
  logic       fch_predict = 1'b0;
  logic [3:0] fch_addr_nxt = '0;
  logic       wrb_update_bpu = 1'b0;
  logic       wrb_was_pred = 1'b0;
  logic [1:0] wrb_ps_state = '0;
  logic [3:0] wrb_ps_addr = '0;
  logic       wrb_direction = 1'b0;
  logic [1:0] ps_rd_data;
  logic       ps_rd_en, ps_wr_en;
  logic [3:0] ps_addr;
  logic [1:0] ps_wr_data, fch_pred_state;
  logic       fch_pred_valid, bpu_busy, uq_full;

  int n_vec = 0;
  int n_err = 0;

  bpu_ps_arbiter #(.PS_SIZE(PS_SIZE), .UQ_LOG2(UQ_LOG2)) dut (
    .clk(clk), .reset(reset), .bpu_flush(bpu_flush),
    .fch_predict(fch_predict), .fch_addr_nxt(fch_addr_nxt),
    .wrb_update_bpu(wrb_update_bpu), .wrb_was_pred(wrb_was_pred),
    .wrb_ps_state(wrb_ps_state), .wrb_ps_addr(wrb_ps_addr),
    .wrb_direction(wrb_direction), .ps_rd_data(ps_rd_data),
    .ps_rd_en(ps_rd_en), .ps_wr_en(ps_wr_en), .ps_addr(ps_addr),
    .ps_wr_data(ps_wr_data), .fch_pred_state(fch_pred_state),
    .fch_pred_valid(fch_pred_valid), .bpu_busy(bpu_busy), .uq_full(uq_full)
  );

  always #5 clk = ~clk;

  // PS RAM: poisoned to 10 during reset so the sweep has to overwrite it.
  logic [1:0] ram [16];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= 2'b10;
      ps_rd_data <= 2'b00;
    end else begin
      if (ps_wr_en) ram[ps_addr] <= ps_wr_data;
      if (ps_rd_en) ps_rd_data <= ram[ps_addr];
    end
  end

  typedef struct {
    logic       pr;
    logic [3:0] fa;
    logic       up, wp;
    logic [1:0] ws;
    logic [3:0] wa;
    logic       wd;
    logic       e_rd, e_wr;
    logic [3:0] e_addr;
    logic [1:0] e_wd, e_pst;
    logic       e_pv, e_full;
  } vec_t;

  vec_t tbl [29];

  function automatic vec_t mk(input int pr, fa, up, wp, ws, wa, wd,
                              input int e_rd, e_wr, e_addr, e_wd, e_pst, e_pv, e_full);
    vec_t v;
    v.pr = pr[0]; v.fa = fa[3:0]; v.up = up[0]; v.wp = wp[0];
    v.ws = ws[1:0]; v.wa = wa[3:0]; v.wd = wd[0];
    v.e_rd = e_rd[0]; v.e_wr = e_wr[0]; v.e_addr = e_addr[3:0];
    v.e_wd = e_wd[1:0]; v.e_pst = e_pst[1:0]; v.e_pv = e_pv[0]; v.e_full = e_full[0];
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int pr, fa, up, wp, ws, wa, wd, fl, rs);
    @(negedge clk);
    fch_predict    = pr[0];
    fch_addr_nxt   = fa[3:0];
    wrb_update_bpu = up[0];
    wrb_was_pred   = wp[0];
    wrb_ps_state   = ws[1:0];
    wrb_ps_addr    = wa[3:0];
    wrb_direction  = wd[0];
    bpu_flush      = fl[0];
    reset          = rs[0];
    #1;
  endtask

  task automatic chk_cycle(input string nm, input int e_rd, e_wr, e_addr, e_wd,
                           input int e_pst, e_pv, e_full, e_busy);
    chk({nm, ".rd_en"}, int'(ps_rd_en), e_rd);
    chk({nm, ".wr_en"}, int'(ps_wr_en), e_wr);
    if (e_rd != 0 || e_wr != 0) chk({nm, ".addr"}, int'(ps_addr), e_addr);
    if (e_wr != 0) chk({nm, ".wr_data"}, int'(ps_wr_data), e_wd);
    chk({nm, ".pred_state"}, int'(fch_pred_state), e_pst);
    chk({nm, ".pred_valid"}, int'(fch_pred_valid), e_pv);
    chk({nm, ".uq_full"}, int'(uq_full), e_full);
    chk({nm, ".busy"}, int'(bpu_busy), e_busy);
  endtask

  // Update and predict traffic is driven throughout the sweep and must be ignored.
  task automatic sweep(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, i, 1, 1, 3, i, 1, 0, 0);
      chk_cycle($sformatf("%s[%0d]", nm, i), 0, 1, i, 1, 1, 0, 0, 1);
    end
  endtask

  initial begin
    //        pr fa up wp ws wa wd   rd wr ad wd pst pv full
    tbl[0]  = mk(0, 0, 1, 1, 3, 3, 1,  0, 0, 0, 1, 1, 0, 0);
    tbl[1]  = mk(0, 0, 1, 1, 0, 3, 0,  0, 1, 3, 3, 1, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 0, 4, 1,  0, 1, 3, 0, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 4, 2, 1, 0, 0);
    tbl[4]  = mk(1, 3, 1, 1, 1, 5, 1,  1, 0, 3, 0, 1, 0, 0);
    tbl[5]  = mk(1, 4, 1, 1, 2, 6, 0,  1, 0, 4, 0, 0, 1, 0);
    tbl[6]  = mk(1, 5, 0, 0, 0, 0, 0,  1, 0, 5, 0, 2, 1, 0);
    tbl[7]  = mk(1, 6, 0, 0, 0, 0, 0,  1, 0, 6, 0, (FWD != 0) ? 2 : 1, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 5, 2, 1, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 6, 1, 1, 0, 0);
    tbl[10] = mk(1, 5, 0, 0, 0, 0, 0,  1, 0, 5, 0, 1, 0, 0);
    tbl[11] = mk(1, 3, 0, 0, 0, 0, 0,  1, 0, 3, 0, 2, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);
    tbl[13] = mk(1, 0, 1, 0, 0, 8, 0,  1, 0, 0, 0, 1, 0, 0);
    tbl[14] = mk(1, 1, 1, 1, 3, 9, 0,  1, 0, 1, 0, 1, 1, 0);
    tbl[15] = mk(1, 2, 1, 1, 0, 10, 1, 1, 0, 2, 0, 1, 1, 0);
    tbl[16] = mk(1, 3, 1, 1, 3, 11, 1, 1, 0, 3, 0, 1, 1, 0);
    tbl[17] = mk(1, 4, 1, 1, 2, 12, 1, 0, 1, 8, 0, 0, 1, 1);
    tbl[18] = mk(1, 4, 0, 0, 0, 0, 0,  0, 1, 9, 2, 1, 0, 1);
    tbl[19] = mk(1, 4, 0, 0, 0, 0, 0,  1, 0, 4, 0, 1, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 10, 1, 2, 1, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 11, 3, 1, 0, 0);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 12, 3, 1, 0, 0);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0);
    tbl[24] = mk(1, 0, 1, 1, 2, 7, 1,  1, 0, 0, 0, 1, 0, 0);
    tbl[25] = mk(1, 7, 0, 0, 0, 0, 0,  1, 0, 7, 0, 1, 1, 0);
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 7, 3, (FWD != 0) ? 3 : 1, 1, 0);
    tbl[27] = mk(1, 7, 0, 0, 0, 0, 0,  1, 0, 7, 0, 1, 0, 0);
    tbl[28] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3, 1, 0);

    // Reset: strobes gated even with predict/update requested.
    repeat (2) @(negedge clk);
    drive(1, 9, 1, 1, 3, 9, 1, 0, 1);
    chk_cycle("reset", 0, 0, 0, 0, 1, 0, 0, 1);

    sweep("sweep", 16);

    foreach (tbl[i]) begin
      drive(tbl[i].pr, tbl[i].fa, tbl[i].up, tbl[i].wp, tbl[i].ws, tbl[i].wa, tbl[i].wd, 0, 0);
      chk_cycle($sformatf("vec%0d", i), tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_addr,
                tbl[i].e_wd, tbl[i].e_pst, tbl[i].e_pv, tbl[i].e_full, 0);
    end

    // Flush mid-drain: three updates (entries 5..7 -> 11) held back by reads.
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 1, 1, 3, 5 + k, 1, 0, 0);
      chk($sformatf("fq%0d.rd_en", k), int'(ps_rd_en), 1);
      chk($sformatf("fq%0d.wr_en", k), int'(ps_wr_en), 0);
    end
    drive(0, 0, 1, 1, 3, 5, 1, 1, 0);
    chk("flush.wr_en", int'(ps_wr_en), 0);
    chk("flush.rd_en", int'(ps_rd_en), 0);
    sweep("fsweep", 5);
    drive(1, 0, 1, 1, 3, 5, 1, 1, 0);
    chk("flush_init.wr_en", int'(ps_wr_en), 0);
    sweep("fsweep2", 16);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk_cycle($sformatf("post_flush%0d", k), 0, 0, 0, 0, 1, 0, 0, 0);
    end
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
    chk_cycle("rd5", 1, 0, 5, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_cycle("rd5_data", 0, 0, 0, 0, 1, 1, 0, 0);

    // Reset while the queue is full and draining.
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 1, 1, 1, k + 1, 1, 0, 0);
      chk($sformatf("rq%0d.uq_full", k), int'(uq_full), 0);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rq_full.uq_full", int'(uq_full), 1);
    chk("rq_full.wr_en", int'(ps_wr_en), 1);
    chk("rq_full.rd_en", int'(ps_rd_en), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rq_reset.wr_en", int'(ps_wr_en), 0);
    sweep("rsweep", 16);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_cycle("post_reset", 0, 0, 0, 0, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
